// File: rtl/stage1_get_delta_signal.sv
// Trapezoidal shaper stage 1: d(n) = x(n) - x(n-K) - x(n-L) + x(n-K-L).
// Optional gain/saturation stage built when STAGE1_GAIN_EN is defined.
module stage1_get_delta_signal #(
    parameter int DATA_W = 14,
    parameter int OUT_W  = 32,
    parameter int K      = 16,
    parameter int L      = 32,
    parameter int SHIFT  = 0
) (
    input  logic                     SYS_CLK,
    input  logic                     RESET_N,
    input  logic signed [DATA_W-1:0] DATAIN,
    input  logic                     DIN_VALID,
    output logic signed [OUT_W-1:0]  DATAOUT,
    output logic                     DOUT_VALID,
    output logic                     PRIMED
);

    localparam int N   = K + L;
    localparam int PW  = $clog2(N);
    localparam int FW  = $clog2(N + 1);
    localparam int NM1 = N - 1;

    localparam logic [PW:0]   N_P   = N[PW:0];
    localparam logic [PW:0]   K_P   = K[PW:0];
    localparam logic [PW:0]   L_P   = L[PW:0];
    localparam logic [PW-1:0] LAST  = NM1[PW-1:0];
    localparam logic [FW-1:0] K_F   = K[FW-1:0];
    localparam logic [FW-1:0] L_F   = L[FW-1:0];
    localparam logic [FW-1:0] N_F   = N[FW-1:0];

    // Configuration sanity: shape lengths and non-negative gain shift
    if (K < 1 || L <= K || N > 256 || SHIFT < 0 || OUT_W < DATA_W + 2) begin : g_bad_cfg
        $error("stage1_get_delta_signal: illegal parameter set");
    end

    logic signed [DATA_W-1:0] mem [N];
    logic [PW-1:0]            wr_ptr;
    logic [FW-1:0]            fill;

    logic [PW:0]              sum_k;
    logic [PW:0]              sum_l;
    logic [PW-1:0]            idx_k;
    logic [PW-1:0]            idx_l;
    logic signed [DATA_W-1:0] x_k;
    logic signed [DATA_W-1:0] x_l;
    logic signed [DATA_W-1:0] x_kl;
    logic signed [OUT_W-1:0]  d;
    logic signed [OUT_W-1:0]  q;

    // Tap addresses: the K-old sample sits L slots ahead of the write slot
    always_comb begin
        sum_k = {1'b0, wr_ptr} + L_P;
        sum_l = {1'b0, wr_ptr} + K_P;
        idx_k = (sum_k >= N_P) ? PW'(sum_k - N_P) : PW'(sum_k);
        idx_l = (sum_l >= N_P) ? PW'(sum_l - N_P) : PW'(sum_l);
    end

    // Taps read as zero until enough history exists since reset
    always_comb begin
        x_k  = (fill >= K_F) ? mem[idx_k]  : '0;
        x_l  = (fill >= L_F) ? mem[idx_l]  : '0;
        x_kl = (fill >= N_F) ? mem[wr_ptr] : '0;
    end

    // Exact difference in the output width
    always_comb begin
        d = OUT_W'(DATAIN) - OUT_W'(x_k) - OUT_W'(x_l) + OUT_W'(x_kl);
    end

`ifdef STAGE1_GAIN_EN
    localparam int GW = OUT_W + SHIFT;
    localparam logic signed [GW-1:0] G_MAX =
        GW'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [GW-1:0] G_MIN = ~G_MAX;

    logic signed [GW-1:0] g;

    // Scale by 2^SHIFT and clamp into the output range
    always_comb begin
        g = GW'(d) <<< SHIFT;
        if (g > G_MAX) begin
            q = G_MAX[OUT_W-1:0];
        end else if (g < G_MIN) begin
            q = G_MIN[OUT_W-1:0];
        end else begin
            q = g[OUT_W-1:0];
        end
    end
`else
    // Gain disabled: pass the difference straight through
    always_comb begin
        q = d;
    end
`endif

    // Sample history; deliberately not reset, fill gating hides stale data
    always_ff @(posedge SYS_CLK) begin
        if (DIN_VALID) begin
            mem[wr_ptr] <= DATAIN;
        end
    end

    // Pointer, fill count and registered output; idle cycles emit zero
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            fill       <= '0;
            DATAOUT    <= '0;
            DOUT_VALID <= 1'b0;
        end else begin
            DOUT_VALID <= DIN_VALID;
            DATAOUT    <= DIN_VALID ? q : '0;
            if (DIN_VALID) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                if (fill != N_F) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    assign PRIMED = (fill == N_F);

endmodule

// File: tb/tb_stage1_get_delta_signal.sv
// Bench for stage1_get_delta_signal with K=4, L=8.
// Sample-history model checked every cycle plus literal expectations.
module tb_stage1_get_delta_signal;

    localparam int DATA_W = 14;
    localparam int K      = 4;
    localparam int L      = 8;
    localparam int N      = K + L;
`ifdef STAGE1_GAIN_EN
    localparam int SHIFT  = 10;
    localparam int OUT_W  = 20;
`else
    localparam int SHIFT  = 0;
    localparam int OUT_W  = 32;
`endif

    logic                     SYS_CLK;
    logic                     RESET_N;
    logic signed [DATA_W-1:0] DATAIN;
    logic                     DIN_VALID;
    logic signed [OUT_W-1:0]  DATAOUT;
    logic                     DOUT_VALID;
    logic                     PRIMED;

    stage1_get_delta_signal #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .K(K), .L(L), .SHIFT(SHIFT)
    ) dut (
        .SYS_CLK   (SYS_CLK),
        .RESET_N   (RESET_N),
        .DATAIN    (DATAIN),
        .DIN_VALID (DIN_VALID),
        .DATAOUT   (DATAOUT),
        .DOUT_VALID(DOUT_VALID),
        .PRIMED    (PRIMED)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    int     npass = 0;
    int     ntot  = 0;
    longint hist[$];
    longint obs[$];
    longint exp_d = 0;
    bit     exp_v = 0;
    bit     exp_p = 0;
    longint acc   = 0;
    longint accmax = 0;

    task automatic check(input string nm, input longint got, input longint exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    function automatic longint shape(input longint v);
        longint r;
        longint hi;
        r  = v;
`ifdef STAGE1_GAIN_EN
        r  = v * (longint'(1) << SHIFT);
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        if (r > hi) r = hi;
        if (r < -hi - 1) r = -hi - 1;
`else
        hi = 0;
`endif
        return r + hi * 0;
    endfunction

    // Reference: keep every sample since reset, apply the delta rule directly
    initial forever begin
        int     n;
        longint d;
        @(posedge SYS_CLK or negedge RESET_N);
        if (!RESET_N) begin
            hist.delete();
            exp_v = 0;
            exp_d = 0;
        end else if (DIN_VALID) begin
            hist.push_back(longint'(DATAIN));
            n = hist.size() - 1;
            d = hist[n];
            if (n >= K) d -= hist[n-K];
            if (n >= L) d -= hist[n-L];
            if (n >= N) d += hist[n-N];
            exp_d = shape(d);
            exp_v = 1;
        end else begin
            exp_v = 0;
            exp_d = 0;
        end
        exp_p = (hist.size() >= N);
    end

    // Compare on the falling edge, away from the active edge
    initial forever begin
        @(negedge SYS_CLK);
        check("dout_valid", DOUT_VALID, exp_v);
        check("dataout", longint'(DATAOUT), exp_d);
        check("primed", PRIMED, exp_p);
        if (DOUT_VALID) obs.push_back(longint'(DATAOUT));
        acc += longint'(DATAOUT);
        if (acc > accmax) accmax = acc;
    end

    task automatic step(input bit v, input logic signed [DATA_W-1:0] x);
        DIN_VALID = v;
        DATAIN    = x;
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic do_reset();
        DIN_VALID = 0;
        #3 RESET_N = 0;
        repeat (2) @(posedge SYS_CLK);
        #1 RESET_N = 1;
        obs.delete();
        acc    = 0;
        accmax = 0;
    endtask

    function automatic longint step_lit(input int i);
        if (i < 4)  return shape(100);
        if (i < 8)  return 0;
        if (i < 12) return shape(-100);
        return 0;
    endfunction

    initial begin
        RESET_N   = 1;
        DIN_VALID = 0;
        DATAIN    = '0;
        #1 RESET_N = 0;
        repeat (2) @(posedge SYS_CLK);
        #1 RESET_N = 1;

        // Step of 100 every clock; also the trapezoid shape
        for (int i = 0; i < 20; i++) begin
            step(1, 100);
            if (i == 10) check("primed_after_11", PRIMED, 0);
            if (i == 11) check("primed_after_12", PRIMED, 1);
        end
        step(0, 0);
        check("step_count", obs.size(), 20);
        for (int i = 0; i < 16 && i < obs.size(); i++)
            check($sformatf("step_d%0d", i), obs[i], step_lit(i));
        check("trap_peak", accmax, 4 * shape(100));
        check("trap_return", acc, 0);

        // Same step with a sample every third clock
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 100);
            step(0, DATA_W'($urandom));
            step(0, DATA_W'($urandom));
        end
        check("gap_count", obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++)
            check($sformatf("gap_d%0d", i), obs[i], step_lit(i));

        // Full-scale alternating input
        do_reset();
        for (int i = 0; i < 26; i++)
            step(1, (i % 2 == 0) ? 14'sd8191 : -14'sd8192);
        step(0, 0);
        if (obs.size() >= 21) begin
            check("alt_d1", obs[1], shape(-8192));
            check("alt_d8", obs[8], shape(-8191));
            check("alt_d20", obs[20], 0);
        end else begin
            check("alt_count", obs.size(), 26);
        end

        // Reset mid-stream must discard history
        do_reset();
        for (int i = 0; i < 6; i++) step(1, DATA_W'($urandom));
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 50);
        step(0, 0);
        check("rst_count", obs.size(), 5);
        for (int i = 0; i < 5 && i < obs.size(); i++)
            check($sformatf("rst_d%0d", i), obs[i], (i < 4) ? shape(50) : 0);

`ifdef STAGE1_GAIN_EN
        // Gain clamp with a full-scale step
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 14'sd8191);
        step(0, 0);
        if (obs.size() >= 9) begin
            check("gain_hi", obs[0], 524287);
            check("gain_lo", obs[8], -524288);
        end else begin
            check("gain_count", obs.size(), 10);
        end
`endif

        // Random valid pattern and data
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, DATA_W'($urandom));
        repeat (2) step(0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
